// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU op enumeration and result-register state encoding
package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/alu_compute_unit.sv
// alu_compute_unit: combinational 32-bit ALU; undefined op codes yield 0
module alu_compute_unit
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << b[4:0];
      OP_SRL:  y = a >> b[4:0];
      OP_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: y = {31'b0, a < b};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one ALU with a one-entry result register
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag
);
  out_state_e       state_q, state_d;
  logic             ptr_q, ptr_d, src_q, src_d;
  logic [31:0]      result_q, result_d, alu_a, alu_b, alu_y;
  logic [3:0]       alu_op;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             can_accept, gnt1, xfer;
  alu_compute_unit u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .y(alu_y));
  always_comb begin
    can_accept = rst_n && (state_q == ST_EMPTY || rsp_ready);
    gnt1       = req1_valid && (!req0_valid || ptr_q);
    req0_ready = can_accept && req0_valid && !gnt1;
    req1_ready = can_accept && gnt1;
    xfer       = req0_ready || req1_ready;
    alu_op     = gnt1 ? req1_op : req0_op;
    alu_a      = gnt1 ? req1_a : req0_a;
    alu_b      = gnt1 ? req1_b : req0_b;
    state_d    = xfer ? ST_FULL : (rsp_ready ? ST_EMPTY : state_q);
    ptr_d      = xfer ? !gnt1 : ptr_q;
    result_d   = xfer ? alu_y : result_q;
    src_d      = xfer ? gnt1 : src_q;
    tag_d      = xfer ? (gnt1 ? req1_tag : req0_tag) : tag_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= 1'b0;
      result_q <= '0;
      src_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      src_q    <= src_d;
      tag_q    <= tag_d;
    end
  end
  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_result = result_q;
  assign rsp_src    = src_q;
  assign rsp_tag    = tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a transaction-level arbiter/ALU reference model
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_src;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  typedef struct {
    logic [31:0] r;
    logic        s;
    logic [3:0]  t;
  } exp_t;
  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  logic m_full = 1'b0, m_ptr = 1'b0, m_xfer = 1'b0, m_src = 1'b0;
  alu_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_src(rsp_src), .rsp_tag(rsp_tag)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = 32'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a + ~b + 32'd1;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic rn, input logic rr,
                      input logic v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] t0,
                      input logic v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1);
    logic can, g1, e0, e1;
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 1'b0;
      sb.delete();
    end else if (m_xfer) begin
      m_full = 1'b1;
      m_ptr  = !m_src;
    end else if (rsp_ready) m_full = 1'b0;
    #1;
    rst_n = rn; rsp_ready = rr;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0; req0_tag = t0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1; req1_tag = t1;
    @(negedge clk);
    can = rn && (!m_full || rr);
    g1  = v1 && (!v0 || m_ptr);
    e0  = can && v0 && !g1;
    e1  = can && g1;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    m_xfer = e0 || e1;
    m_src  = g1;
    if (m_xfer) sb.push_back(g1 ? exp_t'{ref_alu(o1, a1, b1), 1'b1, t1} : exp_t'{ref_alu(o0, a0, b0), 1'b0, t0});
  endtask
  task automatic idle(input logic rn, input logic rr);
    step(rn, rr, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
  endtask
  always @(negedge clk) begin
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got result 0x%08h expected no response at %0t", rsp_result, $time);
      end else begin
        chk("rsp_result", rsp_result, sb[0].r);
        chk("rsp_src", 32'(rsp_src), 32'(sb[0].s));
        chk("rsp_tag", 32'(rsp_tag), 32'(sb[0].t));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end
  initial begin
    repeat (3) idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_tag", 32'(rsp_tag), 32'd0);
    step(1'b1, 1'b1, 1'b1, 4'd0, 32'd5, 32'd7, 4'd3, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    chk("add_accept", 32'(req0_ready), 32'd1);
    idle(1'b1, 1'b1);
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_src", 32'(rsp_src), 32'd0);
    chk("add_tag", 32'(rsp_tag), 32'd3);
    idle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'd0, 32'(i), 32'd100, 4'(i), 1'b1, 4'd1, 32'd100, 32'(i), 4'(i + 8));
      chk("rr_grant0", 32'(req0_ready), 32'((i % 2) == 0));
      chk("rr_grant1", 32'(req1_ready), 32'((i % 2) == 1));
      if (i > 0) chk("rr_src", 32'(rsp_src), 32'((i % 2) == 0));
    end
    idle(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 4'd7, 32'h8000_0000, 32'h24, 4'd9);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 4'd0, 32'd1, 32'd1, 4'd1, 1'b1, 4'd0, 32'd2, 32'd2, 4'd2);
      chk("sra_hold", rsp_result, 32'hF800_0000);
      chk("sra_ready0", 32'(req0_ready), 32'd0);
      chk("sra_ready1", 32'(req1_ready), 32'd0);
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("sra_released", 32'(rsp_valid), 32'd0);
    step(1'b1, 1'b1, 1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1, 4'd4, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 4'd5, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    chk("slt", rsp_result, 32'd1);
    step(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 4'hF, 32'd123, 32'd456, 4'd6);
    chk("sltu", rsp_result, 32'd0);
    idle(1'b1, 1'b1);
    chk("undef_valid", 32'(rsp_valid), 32'd1);
    chk("undef_result", rsp_result, 32'd0);
    chk("undef_tag", 32'(rsp_tag), 32'd6);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 4'd0, 32'd40, 32'd2, 4'd7);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'd0, 32'd1, 32'd1, 4'd1, 1'b1, 4'd0, 32'd2, 32'd2, 4'd2);
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_result", rsp_result, 32'd0);
    chk("rst_mid_grant", 32'(req0_ready), 32'd1);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] b0, b1;
      b0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      step($urandom_range(0, 49) != 0, 1'($urandom),
           1'($urandom), 4'($urandom_range(0, 15)), $urandom, b0, 4'($urandom),
           1'($urandom), 4'($urandom_range(0, 15)), $urandom, b1, 4'($urandom));
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("drain_queue", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
